// File: rtl/ucode_seq_gen2.sv
// Microcode sequencer: generates the ROM address, registers the returned control word and
// handles next/jump/branch/call/return/end sequencing with a hardware return stack.
module ucode_seq_gen2 #(
  parameter int unsigned        ADDR_W       = 9,
  parameter int unsigned        WORD_W       = 64,
  parameter int unsigned        STK_DEPTH    = 4,
  parameter logic [WORD_W-1:0]  DEFAULT_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stall,
  input  logic              kill,
  input  logic              abort,
  input  logic              cond,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WORD_W-1:0] uword,
  output logic              busy,
  output logic              done,
  output logic              stk_err
);

  localparam int unsigned SP_W = $clog2(STK_DEPTH + 1);

  localparam logic [2:0] OpJmp  = 3'd1;
  localparam logic [2:0] OpBrc  = 3'd2;
  localparam logic [2:0] OpCall = 3'd3;
  localparam logic [2:0] OpRet  = 3'd4;
  localparam logic [2:0] OpEnd  = 3'd5;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [ADDR_W-1:0]   stk_q [STK_DEPTH];
  logic [ADDR_W-1:0]   stk_d [STK_DEPTH];
  logic [WORD_W-1:0]   uword_q, uword_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [2:0]          op;
  logic [ADDR_W-1:0]   tgt;
  logic [ADDR_W-1:0]   inc;
  logic [ADDR_W-1:0]   top;
  logic [ADDR_W-1:0]   nxt;
  logic                advance;

  always_comb begin
    op  = uword_q[WORD_W-1 -: 3];
    tgt = uword_q[WORD_W-4 -: ADDR_W];
    inc = pc_q + ADDR_W'(1);

    // Top of stack lives at sp-1; a loop keeps the index width independent of STK_DEPTH.
    top = '0;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top = stk_q[i];
    end

    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    stk_d    = stk_q;
    uword_d  = uword_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rom_addr = pc_q;
    nxt      = inc;
    advance  = 1'b0;

    unique case (state_q)
      StIdle: begin
        rom_addr = start_addr;
        if (start && !kill) begin
          pc_d    = start_addr;
          uword_d = rom_data;
          err_d   = 1'b0;
          sp_d    = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (kill) begin
          state_d = StIdle;
          uword_d = DEFAULT_WORD;
          sp_d    = '0;
        end else if (!stall) begin
          advance = 1'b1;
          case (op)
            OpJmp: nxt = tgt;
            OpBrc: nxt = cond ? tgt : inc;
            OpCall: begin
              if (sp_q == SP_W'(STK_DEPTH)) begin
                advance = 1'b0;
                err_d   = 1'b1;
                state_d = StIdle;
                uword_d = DEFAULT_WORD;
              end else begin
                for (int i = 0; i < STK_DEPTH; i++) begin
                  if (sp_q == SP_W'(i)) stk_d[i] = inc;
                end
                sp_d = sp_q + SP_W'(1);
                nxt  = tgt;
              end
            end
            OpRet: begin
              if (sp_q == '0) begin
                advance = 1'b0;
                err_d   = 1'b1;
                state_d = StIdle;
                uword_d = DEFAULT_WORD;
              end else begin
                sp_d = sp_q - SP_W'(1);
                nxt  = top;
              end
            end
            OpEnd: begin
              advance = 1'b0;
              done_d  = 1'b1;
              state_d = StIdle;
              uword_d = DEFAULT_WORD;
            end
            // NEXT and the reserved opcodes all fall through to the incremented pc.
            default: nxt = inc;
          endcase
          rom_addr = nxt;
          if (advance) begin
            pc_d    = nxt;
            uword_d = rom_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      pc_q    <= '0;
      sp_q    <= '0;
      for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
      uword_q <= DEFAULT_WORD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= stk_d[i];
      uword_q <= uword_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign uword   = abort ? DEFAULT_WORD : uword_q;
  assign busy    = (state_q == StRun);
  assign done    = done_q;
  assign stk_err = err_q;

endmodule
